sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning implemented word-address bits (storage depth is 2**ADDR_W x 16).
REQ-002 SHALL have parameter READ_LAT, default 2, meaning read latency in Clk cycles (legal range 1..15).
REQ-003 SHALL have port Clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port CE  input  1  chip enable, active low.
REQ-006 SHALL have port OE  input  1  output enable (read strobe), active low.
REQ-007 SHALL have port WE  input  1  write enable, active low.
REQ-008 SHALL have port UB  input  1  upper byte lane enable (Data[15:8]), active low.
REQ-009 SHALL have port LB  input  1  lower byte lane enable (Data[7:0]), active low.
REQ-010 SHALL have port ADDR  input  20  word address.
REQ-011 SHALL have port Data  inout  16  shared data bus; driven only during a read, otherwise high-Z.
REQ-012 SHALL have port Busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port Err  output  1  sticky error flag.

Function
REQ-014 SHALL sample CE, OE, WE, UB, LB, ADDR and Data on every rising Clk edge; no combinational path from ADDR to the storage array.
REQ-015 SHALL implement FSM states IDLE, RD_WAIT, RD_DRIVE and WR_HOLD.
REQ-016 SHALL treat an access as in range when ADDR[19:ADDR_W] == 0; out of range otherwise.
REQ-017 IDLE: CE=0 and WE=0 -> WR_HOLD; CE=0, WE=1, OE=0 -> RD_WAIT, latching ADDR and loading the latency counter with READ_LAT-1; all other inputs -> stay in IDLE.
REQ-018 SHALL give WE priority when CE=0, OE=0 and WE=0 in the same cycle: the access is a write and Err is set.
REQ-019 RD_WAIT: counter decrements each cycle; at 0, the latched word is loaded into the output register -> RD_DRIVE. First driven cycle is READ_LAT cycles after the request-sampling edge.
REQ-020 RD_DRIVE: Data = output register on lanes whose enable is low; disabled lanes are high-Z. Stays in RD_DRIVE while CE=0, OE=0, WE=1 and ADDR is unchanged.
REQ-021 RD_DRIVE exits: ADDR change with strobes still asserted -> RD_WAIT (relatch, full READ_LAT restart); CE=1 or OE=1 -> IDLE; WE=0 -> WR_HOLD.
REQ-022 SHALL gate the Data drive enable combinationally with (~CE & ~OE & WE), so the bus is released in the same cycle that a strobe deasserts and never contends with a writer.
REQ-023 SHALL make an out-of-range read drive 16'h0000 on the enabled lanes and set Err.
REQ-024 WR_HOLD: each edge with CE=0 and WE=0 captures ADDR, Data, UB and LB into holding registers.
REQ-025 WR_HOLD commit: on the first edge with CE=1 or WE=1, the held word is written to the array on held-enabled lanes only -> IDLE (or -> RD_WAIT if CE=0, OE=0, WE=1 on that edge).
REQ-026 SHALL drop an out-of-range write at commit and set Err.
REQ-027 SHALL write nothing when both held lanes are disabled (UB=LB=1); that case is not an error.
REQ-028 Err SHALL stay set until reset.
REQ-029 Busy SHALL be registered (derived from the next-state value).

Reset
REQ-030 SHALL, on Reset=0, asynchronously force: state IDLE, Busy=0, Err=0, Data high-Z, counter 0, holding registers 0.
REQ-031 SHALL leave storage array contents unaffected by reset.
REQ-032 SHALL discard an in-flight write on reset mid-WR_HOLD (no commit) and abort an in-flight read without driving Data.
REQ-033 SHALL ignore bus strobes until the first rising edge after Reset returns to 1.

Verification
REQ-034 Write ADDR=20'h00010, Data=16'hBEEF, UB=LB=0, WE low 2 cycles then high; then read the same address -> Data=16'hBEEF exactly 2 cycles after the read-sampling edge; Busy high through RD_WAIT.
REQ-035 Byte-lane write 16'h12xx with LB=1 over a stored 16'hBEEF -> readback 16'h12EF; a read with UB=1 -> Data[15:8]=Z, Data[7:0]=8'hEF.
REQ-036 Out-of-range: ADDR=20'h10000 (ADDR_W=16) write 16'h5555, then read -> Data=16'h0000, Err=1 and stays 1 until Reset=0.
REQ-037 Read with OE deasserted in the RD_DRIVE cycle -> Data high-Z in that same cycle; ADDR change mid-RD_DRIVE -> new word after READ_LAT cycles.
REQ-038 Reset=0 while WE is low on 20'h00020 (prior 16'hAAAA) -> after reset, readback 16'hAAAA, Busy=0, Err=0.
REQ-039 CE=OE=WE=0 simultaneously -> treated as a write, Data never driven, Err=1.

Source files
------------

// File: rtl/sram_responder_if.sv
// Strobe, address and status signals of the synchronous SRAM responder.
// The shared 16-bit data bus is a separate inout net on the responder.
interface sram_responder_if;
    localparam int unsigned AW = 20;

    logic          CE;
    logic          OE;
    logic          WE;
    logic          UB;
    logic          LB;
    logic [AW-1:0] ADDR;
    logic          Busy;
    logic          Err;

    modport master (
        output CE, OE, WE, UB, LB, ADDR,
        input  Busy, Err
    );

    modport slave (
        input  CE, OE, WE, UB, LB, ADDR,
        output Busy, Err
    );
endinterface

// File: rtl/sram_responder.sv
// Synchronous SRAM responder: registered strobe sampling, latency-programmable reads,
// held writes committed on strobe release, byte lanes and a sticky error flag.
module sram_responder #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned READ_LAT = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    sram_responder_if.slave  bus,
    inout  wire  [15:0]      Data
);
    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = 16;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [AW-1:0]    rd_addr, rd_addr_nxt;
    logic [AW-1:0]    hold_addr, hold_addr_nxt;
    logic [DW-1:0]    hold_data, hold_data_nxt;
    logic             hold_ub, hold_ub_nxt;
    logic             hold_lb, hold_lb_nxt;
    logic [DW-1:0]    dout, dout_nxt;
    logic             busy;
    logic             err, err_nxt;
    logic             wr_hi_c, wr_lo_c;
    logic             req_wr_c, req_rd_c, drive_c;

    logic [DW-1:0]    mem [DEPTH];

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >> ADDR_W) == '0;
    endfunction

    assign req_wr_c = ~bus.CE & ~bus.WE;
    assign req_rd_c = ~bus.CE & ~bus.OE & bus.WE;

    // Next-state and datapath control
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rd_addr_nxt   = rd_addr;
        hold_addr_nxt = hold_addr;
        hold_data_nxt = hold_data;
        hold_ub_nxt   = hold_ub;
        hold_lb_nxt   = hold_lb;
        dout_nxt      = dout;
        err_nxt       = err | (~bus.CE & ~bus.OE & ~bus.WE);
        wr_hi_c       = 1'b0;
        wr_lo_c       = 1'b0;

        case (state)
            IDLE: begin
                if (req_wr_c) begin
                    state_nxt     = WR_HOLD;
                    hold_addr_nxt = bus.ADDR;
                    hold_data_nxt = Data;
                    hold_ub_nxt   = bus.UB;
                    hold_lb_nxt   = bus.LB;
                end else if (req_rd_c) begin
                    state_nxt   = RD_WAIT;
                    rd_addr_nxt = bus.ADDR;
                    cnt_nxt     = LAT_LOAD;
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RD_DRIVE;
                    if (in_range(rd_addr)) begin
                        dout_nxt = mem[rd_addr[ADDR_W-1:0]];
                    end else begin
                        dout_nxt = '0;
                        err_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RD_DRIVE: begin
                if (bus.CE | bus.OE) begin
                    state_nxt = IDLE;
                end else if (~bus.WE) begin
                    state_nxt     = WR_HOLD;
                    hold_addr_nxt = bus.ADDR;
                    hold_data_nxt = Data;
                    hold_ub_nxt   = bus.UB;
                    hold_lb_nxt   = bus.LB;
                end else if (bus.ADDR != rd_addr) begin
                    // Address moved under an open read: restart the full latency
                    state_nxt   = RD_WAIT;
                    rd_addr_nxt = bus.ADDR;
                    cnt_nxt     = LAT_LOAD;
                end
            end
            WR_HOLD: begin
                if (req_wr_c) begin
                    hold_addr_nxt = bus.ADDR;
                    hold_data_nxt = Data;
                    hold_ub_nxt   = bus.UB;
                    hold_lb_nxt   = bus.LB;
                end else begin
                    if (in_range(hold_addr)) begin
                        wr_hi_c = ~hold_ub;
                        wr_lo_c = ~hold_lb;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    if (req_rd_c) begin
                        state_nxt   = RD_WAIT;
                        rd_addr_nxt = bus.ADDR;
                        cnt_nxt     = LAT_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and control registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_addr   <= '0;
            hold_addr <= '0;
            hold_data <= '0;
            hold_ub   <= 1'b0;
            hold_lb   <= 1'b0;
            dout      <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rd_addr   <= rd_addr_nxt;
            hold_addr <= hold_addr_nxt;
            hold_data <= hold_data_nxt;
            hold_ub   <= hold_ub_nxt;
            hold_lb   <= hold_lb_nxt;
            dout      <= dout_nxt;
            busy      <= (state_nxt != IDLE);
            err       <= err_nxt;
        end
    end

    // Storage array is deliberately outside reset so contents survive it
    always_ff @(posedge Clk) begin
        if (wr_hi_c) mem[hold_addr[ADDR_W-1:0]][15:8] <= hold_data[15:8];
        if (wr_lo_c) mem[hold_addr[ADDR_W-1:0]][7:0]  <= hold_data[7:0];
    end

    // Live strobes gate the drive so the bus frees in the cycle a strobe drops
    assign drive_c    = (state == RD_DRIVE) & req_rd_c;
    assign Data[15:8] = (drive_c & ~bus.UB) ? dout[15:8] : 8'hzz;
    assign Data[7:0]  = (drive_c & ~bus.LB) ? dout[7:0]  : 8'hzz;

    assign bus.Busy = busy;
    assign bus.Err  = err;
endmodule

// File: tb/tb_sram_responder.sv
// Directed and randomized checks of sram_responder against a word-level memory model.
// The data bus is pulled up, so an undriven lane reads as 8'hFF.
module tb_sram_responder;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned READ_LAT = 2;
    localparam logic [15:0] HIZ      = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tb_drv = 1'b0;
    logic [15:0] tb_data = 16'h0000;
    wire  [15:0] data_bus;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] ref_mem [int unsigned];
    logic        ref_err = 1'b0;
    logic [19:0] pool [8];

    sram_responder_if bus_if ();

    assign data_bus = tb_drv ? tb_data : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pull
        pullup (data_bus[i]);
    end

    sram_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus_if.slave),
        .Data  (data_bus)
    );

    always #5 clk = ~clk;

    function automatic logic model_in_range(input logic [19:0] a);
        return int'(a) < (1 << ADDR_W);
    endfunction

    task automatic model_write(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
        logic [15:0] w;
        if (!model_in_range(a)) begin
            ref_err = 1'b1;
        end else begin
            w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
            if (!ub) w = {d[15:8], w[7:0]};
            if (!lb) w = {w[15:8], d[7:0]};
            ref_mem[int'(a)] = w;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb, input int hold);
        bus_if.CE = 1'b0; bus_if.WE = 1'b0; bus_if.OE = 1'b1;
        bus_if.ADDR = a; bus_if.UB = ub; bus_if.LB = lb;
        tb_drv = 1'b1; tb_data = d;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("wr_busy", 16'(bus_if.Busy), 16'h0001);
        end
        bus_if.CE = 1'b1; bus_if.WE = 1'b1; tb_drv = 1'b0;
        step();
        model_write(a, d, ub, lb);
        chk("wr_idle_busy", 16'(bus_if.Busy), 16'h0000);
        chk("wr_err", 16'(bus_if.Err), 16'(ref_err));
    endtask

    task automatic rd_start(input logic [19:0] a, input logic ub, input logic lb);
        bus_if.CE = 1'b0; bus_if.OE = 1'b0; bus_if.WE = 1'b1;
        bus_if.ADDR = a; bus_if.UB = ub; bus_if.LB = lb;
        tb_drv = 1'b0;
    endtask

    // Sampling edge, READ_LAT undriven cycles, then the word on enabled lanes
    task automatic rd_wait(input string tag, input logic [19:0] a, input logic ub, input logic lb);
        logic [15:0] w;
        step();
        for (int k = 0; k < int'(READ_LAT); k++) begin
            chk({tag, "_wait_busy"}, 16'(bus_if.Busy), 16'h0001);
            chk({tag, "_wait_hiz"}, data_bus, HIZ);
            step();
        end
        if (model_in_range(a)) begin
            w = ref_mem[int'(a)];
        end else begin
            w = 16'h0000;
            ref_err = 1'b1;
        end
        chk({tag, "_data"}, data_bus, {ub ? 8'hFF : w[15:8], lb ? 8'hFF : w[7:0]});
        chk({tag, "_busy"}, 16'(bus_if.Busy), 16'h0001);
    endtask

    task automatic rd_end(input string tag);
        bus_if.OE = 1'b1;
        #1;
        chk({tag, "_release_hiz"}, data_bus, HIZ);
        step();
        bus_if.CE = 1'b1;
        chk({tag, "_idle_busy"}, 16'(bus_if.Busy), 16'h0000);
        chk({tag, "_err"}, 16'(bus_if.Err), 16'(ref_err));
    endtask

    initial begin
        logic [19:0] a;
        logic [15:0] d;
        logic        ub, lb;

        bus_if.CE = 1'b1; bus_if.OE = 1'b1; bus_if.WE = 1'b1;
        bus_if.UB = 1'b0; bus_if.LB = 1'b0; bus_if.ADDR = '0;
        #1;
        chk("rst_busy", 16'(bus_if.Busy), 16'h0000);
        chk("rst_err", 16'(bus_if.Err), 16'h0000);
        chk("rst_hiz", data_bus, HIZ);
        step(); step();
        rst_n = 1'b1;
        step();

        // Basic write/read
        wr(20'h00010, 16'hBEEF, 1'b0, 1'b0, 2);
        rd_start(20'h00010, 1'b0, 1'b0); rd_wait("beef", 20'h00010, 1'b0, 1'b0); rd_end("beef");

        // Upper-lane-only write, then full and lower-only reads
        wr(20'h00010, 16'h12AB, 1'b0, 1'b1, 1);
        rd_start(20'h00010, 1'b0, 1'b0); rd_wait("lane_full", 20'h00010, 1'b0, 1'b0); rd_end("lane_full");
        rd_start(20'h00010, 1'b1, 1'b0); rd_wait("lane_lo", 20'h00010, 1'b1, 1'b0); rd_end("lane_lo");

        // No-lane write leaves the word intact and is not an error
        wr(20'h00010, 16'h0000, 1'b1, 1'b1, 1);

        // Address change mid-drive restarts the read latency
        wr(20'h00011, 16'h3C3C, 1'b0, 1'b0, 1);
        rd_start(20'h00010, 1'b0, 1'b0); rd_wait("chg_a", 20'h00010, 1'b0, 1'b0);
        bus_if.ADDR = 20'h00011;
        rd_wait("chg_b", 20'h00011, 1'b0, 1'b0); rd_end("chg");

        // Simultaneous CE/OE/WE low is a write; bus stays undriven
        bus_if.CE = 1'b0; bus_if.OE = 1'b0; bus_if.WE = 1'b0;
        bus_if.ADDR = 20'h00030; bus_if.UB = 1'b0; bus_if.LB = 1'b0; tb_drv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("cow_hiz", data_bus, HIZ);
            chk("cow_busy", 16'(bus_if.Busy), 16'h0001);
        end
        bus_if.CE = 1'b1; bus_if.OE = 1'b1; bus_if.WE = 1'b1;
        step();
        ref_err = 1'b1;
        model_write(20'h00030, HIZ, 1'b0, 1'b0);
        chk("cow_err", 16'(bus_if.Err), 16'h0001);
        chk("cow_busy_done", 16'(bus_if.Busy), 16'h0000);

        // Reset mid-write discards the held word and clears Err
        wr(20'h00020, 16'hAAAA, 1'b0, 1'b0, 1);
        bus_if.CE = 1'b0; bus_if.WE = 1'b0; bus_if.ADDR = 20'h00020;
        tb_drv = 1'b1; tb_data = 16'h1234;
        step(); step();
        rst_n = 1'b0;
        #1;
        ref_err = 1'b0;
        chk("rstw_busy", 16'(bus_if.Busy), 16'h0000);
        chk("rstw_err", 16'(bus_if.Err), 16'h0000);
        bus_if.CE = 1'b1; bus_if.WE = 1'b1; tb_drv = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        rd_start(20'h00020, 1'b0, 1'b0); rd_wait("rstw_rd", 20'h00020, 1'b0, 1'b0); rd_end("rstw_rd");

        // Reset during a read aborts it with the bus released
        rd_start(20'h00010, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("rstr_hiz", data_bus, HIZ);
        chk("rstr_busy", 16'(bus_if.Busy), 16'h0000);
        bus_if.CE = 1'b1; bus_if.OE = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Out-of-range write and read: zero data, sticky Err
        wr(20'h10000, 16'h5555, 1'b0, 1'b0, 1);
        rd_start(20'h10000, 1'b0, 1'b0); rd_wait("oor", 20'h10000, 1'b0, 1'b0); rd_end("oor");
        rd_start(20'h00011, 1'b0, 1'b0); rd_wait("oor_after", 20'h00011, 1'b0, 1'b0); rd_end("oor_after");

        // Randomized traffic over a small address pool
        for (int i = 0; i < 8; i++) begin
            pool[i] = (i < 6) ? 20'($urandom_range(0, 16'hFFFF)) : {4'($urandom_range(1, 15)), 16'($urandom)};
            if (i < 6) wr(pool[i], 16'($urandom), 1'b0, 1'b0, 1);
        end
        for (int n = 0; n < 40; n++) begin
            a  = pool[$urandom_range(0, 7)];
            d  = 16'($urandom);
            ub = 1'($urandom);
            lb = 1'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                wr(a, d, ub, lb, int'($urandom_range(1, 3)));
            end else begin
                rd_start(a, ub, lb); rd_wait("rand_rd", a, ub, lb); rd_end("rand_rd");
            end
        end

        rst_n = 1'b0;
        #1;
        chk("final_rst_err", 16'(bus_if.Err), 16'h0000);
        chk("final_rst_busy", 16'(bus_if.Busy), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
